temp_spi_responder: RTL and testbench
=====================================

TEMP_SPI_RESPONDER -- requirements
Module: temp_spi_responder

Interface
REQ-001 Parameter FRAME_BITS, default 16: number of data bits shifted out per CSn frame.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on temp_sck and temp_csn, legal range 2..3.
REQ-003 Port fab_clk_16MHz  input  1: single system clock; all logic rising-edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port temp_sck  input  1: SPI serial clock from the reading master, CPOL=0, asynchronous to fab_clk_16MHz.
REQ-006 Port temp_csn  input  1: SPI chip select from the master, active-low, asynchronous.
REQ-007 Port temp_so  output  1: serial data to the master, MSB first.
REQ-008 Port temp_so_oe  output  1: output enable for temp_so; high only while a frame is selected.
REQ-009 Port temp_value  input  FRAME_BITS: sample to be transmitted, sampled by the block only at frame start.
REQ-010 Port frame_done  output  1: one-cycle pulse, all FRAME_BITS bits clocked out and CSn released.
REQ-011 Port frame_abort  output  1: one-cycle pulse, CSn released before FRAME_BITS bits were clocked.
REQ-012 Port frame_count  output  16: count of completed frames, wraps 0xFFFF->0x0000.

Function
REQ-013 temp_sck and temp_csn SHALL each pass through SYNC_STAGES flops, then one history flop for edge detection; a detected edge is acted on in the following cycle.
REQ-014 Pin-to-action latency SHALL be SYNC_STAGES+1 cycles; the master SHALL keep SCK high and low phases at least 4 fab_clk_16MHz cycles each (SCK <= 2 MHz).
REQ-015 States SHALL be IDLE, SHIFT, TAIL.
REQ-016 IDLE: temp_so=0, temp_so_oe=0; on a synchronized CSn falling edge, load shift register with temp_value, load bit counter with FRAME_BITS-1, drive temp_so=temp_value[MSB], temp_so_oe=1, and go to SHIFT.
REQ-017 SHIFT: the master samples on SCK rising; on each synchronized SCK falling edge, shift left by one, present the next bit on temp_so, and decrement the bit counter.
REQ-018 SHIFT: the falling edge that follows the last bit (counter at 0) SHALL move to TAIL with temp_so=0.
REQ-019 TAIL: temp_so=0, temp_so_oe=1; further SCK edges ignored.
REQ-020 TAIL: on CSn rising edge go to IDLE, pulse frame_done, increment frame_count.
REQ-021 SHIFT: on CSn rising edge go to IDLE, pulse frame_abort, frame_count unchanged, shift register contents discarded.
REQ-022 SCK edges while in IDLE SHALL be ignored.
REQ-023 If CSn rising and SCK falling are detected in the same cycle, CSn SHALL take priority; in SHIFT this gives abort even if it was the final bit's edge.
REQ-024 temp_value changes after frame start SHALL NOT affect the frame in progress.
REQ-025 A CSn falling edge detected in the same cycle as rst SHALL be ignored.
REQ-026 frame_done and frame_abort SHALL never be high in the same cycle and never for more than one cycle.

Reset
REQ-027 While rst is high: state=IDLE, temp_so=0, temp_so_oe=0, frame_done=0, frame_abort=0, frame_count=0, shift register=0, bit counter=0, synchronizer and history flops=1 for CSn and 0 for SCK.
REQ-028 rst asserted mid-frame SHALL abandon the frame with no frame_done or frame_abort pulse.
REQ-029 After rst releases, a frame SHALL start only on a fresh CSn falling edge; if CSn is already low, it SHALL be held high and then driven low again.

Verification
REQ-030 temp_value=0xA5C3, CSn low, 16 SCK cycles at 1 MHz, CSn high -> master reads 0xA5C3 MSB first; one frame_done; frame_count 0->1.
REQ-031 temp_value=0x8001, CSn raised after 7 SCK cycles -> master reads the 7 bits 1000000; frame_abort pulses once; frame_count unchanged; temp_so_oe=0 within SYNC_STAGES+2 cycles.
REQ-032 Frame started with 0x1234, temp_value changed to 0xFFFF after bit 3 -> master reads 0x1234.
REQ-033 20 SCK cycles in one frame with 0x00FF -> bits 0x00FF, then 4 zero bits; frame_done on CSn high.
REQ-034 rst pulsed at bit 9 of a frame -> temp_so_oe=0 next cycle; no pulses; frame_count=0; next full frame with 0x5A5A is read correctly.
REQ-035 frame_count preset to 0xFFFF by 65535 frames, or by forcing the register -> one more complete frame gives frame_count=0x0000.

Source files
------------

// File: rtl/temp_spi_responder.sv
// +----------------------------------------------------------------------+
// | temp_spi_responder: SPI mode-0 responder shifting a sampled value    |
// | out MSB first on a CSn frame.                          Revision: 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module temp_spi_responder #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  fab_clk_16MHz,
  input  logic                  rst,
  input  logic                  temp_sck,
  input  logic                  temp_csn,
  output logic                  temp_so,
  output logic                  temp_so_oe,
  input  logic [FRAME_BITS-1:0] temp_value,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic [15:0]           frame_count
);

  localparam int CW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] flush;
  logic                   sck_hist;
  logic                   csn_hist;
  logic                   armed;

  state_t                 state, state_n;
  logic [FRAME_BITS-1:0]  shreg, shreg_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   so, so_n;
  logic                   oe, oe_n;
  logic                   done, done_n;
  logic                   abort, abort_n;
  logic [15:0]            count, count_n;

  logic                   sck_fall;
  logic                   csn_rise;
  logic                   csn_fall;

  // flush tracks when the chain holds real pin samples rather than reset
  // values; armed then requires CSn to be seen high before any frame starts.
  always_ff @(posedge fab_clk_16MHz) begin
    if (rst) begin
      sck_sync <= '0;
      csn_sync <= '1;
      flush    <= '0;
      sck_hist <= 1'b0;
      csn_hist <= 1'b1;
      armed    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], temp_sck};
      csn_sync <= {csn_sync[SYNC_STAGES-2:0], temp_csn};
      flush    <= {flush[SYNC_STAGES-2:0], 1'b1};
      sck_hist <= sck_sync[SYNC_STAGES-1];
      csn_hist <= csn_sync[SYNC_STAGES-1];
      armed    <= armed | (flush[SYNC_STAGES-1] & csn_sync[SYNC_STAGES-1]);
    end
  end

  assign sck_fall = sck_hist & ~sck_sync[SYNC_STAGES-1];
  assign csn_rise = ~csn_hist & csn_sync[SYNC_STAGES-1];
  assign csn_fall = armed & csn_hist & ~csn_sync[SYNC_STAGES-1];

  always_ff @(posedge fab_clk_16MHz) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      so    <= 1'b0;
      oe    <= 1'b0;
      done  <= 1'b0;
      abort <= 1'b0;
      count <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      so    <= so_n;
      oe    <= oe_n;
      done  <= done_n;
      abort <= abort_n;
      count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    so_n    = so;
    oe_n    = oe;
    done_n  = 1'b0;
    abort_n = 1'b0;
    count_n = count;
    case (state)
      IDLE: begin
        so_n = 1'b0;
        oe_n = 1'b0;
        if (csn_fall) begin
          shreg_n = temp_value;
          cnt_n   = LAST_IDX;
          so_n    = temp_value[FRAME_BITS-1];
          oe_n    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // CSn release wins over a coincident SCK edge, even on the last bit.
        if (csn_rise) begin
          shreg_n = '0;
          cnt_n   = '0;
          so_n    = 1'b0;
          oe_n    = 1'b0;
          abort_n = 1'b1;
          state_n = IDLE;
        end else if (sck_fall) begin
          if (cnt == '0) begin
            so_n    = 1'b0;
            state_n = TAIL;
          end else begin
            shreg_n = shreg << 1;
            so_n    = shreg[FRAME_BITS-2];
            cnt_n   = cnt - CW'(1);
          end
        end
      end
      TAIL: begin
        so_n = 1'b0;
        oe_n = 1'b1;
        if (csn_rise) begin
          shreg_n = '0;
          oe_n    = 1'b0;
          done_n  = 1'b1;
          count_n = count + 16'd1;
          state_n = IDLE;
        end
      end
      default: begin
        so_n    = 1'b0;
        oe_n    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign temp_so     = so;
  assign temp_so_oe  = oe;
  assign frame_done  = done;
  assign frame_abort = abort;
  assign frame_count = count;

endmodule

`default_nettype wire

// File: tb/tb_temp_spi_responder.sv
// +----------------------------------------------------------------------+
// | tb_temp_spi_responder: randomized SPI master driving the responder,  |
// | checked against a bit-level frame model.               Revision: 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_temp_spi_responder;

  localparam int FB = 16;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck;
  logic        csn;
  logic        so;
  logic        oe;
  logic [15:0] value;
  logic        done;
  logic        abort;
  logic [15:0] count;

  int          checks   = 0;
  int          failures = 0;
  int          n_done   = 0;
  int          n_abort  = 0;
  logic [15:0] exp_count = 16'd0;
  logic        prev_done  = 1'b0;
  logic        prev_abort = 1'b0;
  logic [31:0] rd;

  always #31 clk = ~clk;

  temp_spi_responder #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
    .fab_clk_16MHz (clk),
    .rst           (rst),
    .temp_sck      (sck),
    .temp_csn      (csn),
    .temp_so       (so),
    .temp_so_oe    (oe),
    .temp_value    (value),
    .frame_done    (done),
    .frame_abort   (abort),
    .frame_count   (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Bits a mode-0 master reads: the value MSB first, zeros past the frame.
  function automatic logic [31:0] model_bits(input logic [15:0] v, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++)
      r = {r[30:0], (k < FB) ? v[FB-1-k] : 1'b0};
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("pulse_exclusive", {31'd0, done & abort}, 32'd0);
      check("pulse_width", {31'd0, (done & prev_done) | (abort & prev_abort)}, 32'd0);
      check("so_idle_zero", {31'd0, ~oe & so}, 32'd0);
      if (done)  n_done++;
      if (abort) n_abort++;
    end
    prev_done  = done;
    prev_abort = abort;
  end

  task automatic run_frame(input logic [15:0] v, input int nclk, input int chg_at,
                           input logic [15:0] chg_val, input int rst_at,
                           output logic [31:0] bits);
    int ph;
    int d0;
    int a0;
    bit rst_hit;
    int exp_d;
    int exp_a;
    rst_hit = 0;
    bits    = '0;
    ph      = $urandom_range(4, 7);
    value   = v;
    d0      = n_done;
    a0      = n_abort;
    @(negedge clk) csn = 1'b0;
    repeat (ph) @(negedge clk);
    for (int i = 0; i < nclk; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rst_hit = 1;
        exp_count = 16'd0;
        check("oe_after_rst", {31'd0, oe}, 32'd0);
      end
      check("oe_in_frame", {31'd0, oe}, rst_hit ? 32'd0 : 32'd1);
      bits = {bits[30:0], so};
      sck = 1'b1;
      repeat (ph) @(negedge clk);
      sck = 1'b0;
      repeat (ph) @(negedge clk);
      if (i == chg_at) value = chg_val;
    end
    csn = 1'b1;
    repeat (SS + 2) @(negedge clk);
    check("oe_release", {31'd0, oe}, 32'd0);
    repeat (4) @(negedge clk);
    exp_d = (!rst_hit && nclk >= FB) ? 1 : 0;
    exp_a = (!rst_hit && nclk < FB) ? 1 : 0;
    check("done_pulses", n_done - d0, exp_d);
    check("abort_pulses", n_abort - a0, exp_a);
    if (exp_d == 1) exp_count = exp_count + 16'd1;
    check("frame_count", {16'd0, count}, {16'd0, exp_count});
    if (!rst_hit) check("read_bits", bits, model_bits(v, nclk));
  endtask

  initial begin
    rst   = 1'b1;
    sck   = 1'b0;
    csn   = 1'b1;
    value = 16'd0;
    repeat (5) @(negedge clk);
    check("rst_so", {31'd0, so}, 32'd0);
    check("rst_oe", {31'd0, oe}, 32'd0);
    check("rst_pulses", {30'd0, done, abort}, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    run_frame(16'hA5C3, 16, -1, 16'h0000, -1, rd);
    check("lit_a5c3", rd, 32'h0000_A5C3);
    check("lit_count1", {16'd0, count}, 32'd1);
    run_frame(16'h8001, 7, -1, 16'h0000, -1, rd);
    check("lit_8001_7bits", rd, 32'h0000_0040);
    run_frame(16'h1234, 16, 3, 16'hFFFF, -1, rd);
    check("lit_1234", rd, 32'h0000_1234);
    run_frame(16'h00FF, 20, -1, 16'h0000, -1, rd);
    check("lit_00ff_20", rd, 32'h0000_0FF0);

    run_frame(16'hC3C3, 16, -1, 16'h0000, 9, rd);
    check("lit_count_after_rst", {16'd0, count}, 32'd0);
    run_frame(16'h5A5A, 16, -1, 16'h0000, -1, rd);
    check("lit_5a5a", rd, 32'h0000_5A5A);

    for (int n = 0; n < 12; n++)
      run_frame(16'($urandom), $urandom_range(0, 22), $urandom_range(0, 15),
                16'($urandom), -1, rd);

    force dut.count = 16'hFFFF;
    @(negedge clk);
    release dut.count;
    @(negedge clk);
    exp_count = 16'hFFFF;
    check("count_preset", {16'd0, count}, 32'h0000_FFFF);
    run_frame(16'h0F0F, 16, -1, 16'h0000, -1, rd);
    check("lit_count_wrap", {16'd0, count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
